// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub.sv
// One-bit full adder cell; i_x=1 inverts b so a chain of these subtracts.
module add_sub (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_cout,
    input  logic i_x,
    input  logic i_cin
);

    logic w_b;

    assign w_b    = i_b ^ i_x;
    assign o_sum  = i_a ^ w_b ^ i_cin;
    assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);

endmodule

// File: rtl/serial_addsub_seq.sv
// Feeds operands LSB-first through the add_sub cell, closing the carry loop
// in a register, and returns a parallel result with carry-out and overflow.
module serial_addsub_seq
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a_in,
    input  logic [WIDTH-1:0] i_b_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a_sr, r_b_sr, r_s_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op, r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout, r_overflow;

    logic               w_sum, w_cout, w_last;
    logic [WIDTH-1:0]   w_s_next;

    add_sub u_cell (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .i_x    (r_op),
        .i_cin  (r_carry)
    );

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_s_next = {w_sum, r_s_sr[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_s_sr     <= '0;
            r_cnt      <= '0;
            r_op       <= 1'b0;
            r_carry    <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a_sr  <= i_a_in;
                        r_b_sr  <= i_b_in;
                        r_op    <= i_op;
                        // Subtract's +1 enters as the initial carry.
                        r_carry <= i_op;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_s_sr  <= w_s_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result   <= w_s_next;
                        r_cout     <= w_cout;
                        // r_carry is still the carry into the MSB here.
                        r_overflow <= r_carry ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state == ST_SHIFT);
    assign o_done     = (r_state == ST_DONE);
    assign o_result   = r_result;
    assign o_cout     = r_cout;
    assign o_overflow = r_overflow;

endmodule

// File: doc/serial_addsub_seq.md
# serial_addsub_seq

Bit-serial WIDTH-bit add/subtract sequencer that sits directly upstream of the team's one-bit `add_sub` cell. It accepts a parallel operand pair and an operation on a start strobe and feeds the cell one bit per clock, LSB first. It also closes the carry loop through a register and returns a parallel result with carry-out and signed overflow.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 2..32.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `op`  in  1  0 = add (a+b), 1 = subtract (a−b); sampled with `start`.
- `a_in`  in  WIDTH  operand A; sampled with `start`.
- `b_in`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  sum/difference; holds its value until the next completion.
- `cout`  out  1  final carry out. For subtract, 1 = no borrow (a ≥ b unsigned).
- `overflow`  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- Cell contract, per step, with cell inputs `a`, `b`, `cin` and `x`:
  - `x`=0: sum = a^b^cin; cout = majority(a, b, cin).
  - `x`=1: the cell uses ~b in place of b.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When `start`=1:
    - Load shift registers `a_sr`←`a_in` and `b_sr`←`b_in`.
    - `op_r`←`op`, `carry`←`op`, `cnt`←0.
    - Go to SHIFT.
  - When `start`=0: stay in IDLE.
- SHIFT, each cycle:
  - Drive the cell with `a_sr[0]`, `b_sr[0]`, `cin`=`carry` and `x`=`op_r`.
  - Shift the cell sum into the MSB of internal `s_sr` (shift right). Shift `a_sr` and `b_sr` right.
  - `carry`←cell cout. When `cnt`==WIDTH−1, `cmsb`←`carry` (this is the carry into the MSB).
  - `cnt`++.
  - On the step where `cnt`==WIDTH−1:
    - `result`←final `s_sr` including this bit.
    - `cout`←cell cout.
    - `overflow`←`carry`^cell cout.
    - Go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` in SHIFT or DONE is ignored; it is not queued.
- `busy` = (state==SHIFT).
- `result`, `cout` and `overflow` change only on the completing edge. They are never exposed mid-operation.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1.
- Reset in any state:
  - state←IDLE, `busy`=0, `done`=0.
  - `result`=0, `cout`=0, `overflow`=0.
  - `cnt`, `carry` and the shift registers are cleared.
  - Any operation in flight is abandoned with no `done`.

## Timing
- Start edge k: `start`=1 sampled in IDLE.
- `busy` is high for cycles k+1 … k+WIDTH (exactly WIDTH cycles).
- `result`, `cout` and `overflow` are valid from edge k+WIDTH.
- `done` is high for the single cycle following edge k+WIDTH.
- Minimum start-to-start spacing is WIDTH+2 cycles. The earliest re-accept is the first IDLE cycle after DONE.
- `cnt` width is clog2(WIDTH)+1. It never wraps during an operation.
- Simultaneous `rst` and `start`: reset wins and the request is dropped.
- Operand inputs may change freely after the start edge. They are not re-sampled.

## Structure
- Shared package `serial_addsub_pkg` holds:
  - The state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - OP_ADD=1'b0 and OP_SUB=1'b1.
- One sub-module: the existing `add_sub` one-bit cell, instantiated once, with port order (a, b, sum, cout, x, cin).
- Everything else (FSM, counter, shift registers, output registers) is inline in `serial_addsub_seq`.

## Test plan
1. WIDTH=8, add 8'h35+8'h1A → `result`=8'h4F, `cout`=0, `overflow`=0. `done` pulses one cycle, 8 cycles after the start edge; `busy` is high for exactly 8 cycles.
2. Subtract 8'h10−8'h01 → 8'h0F, `cout`=1, `overflow`=0. Subtract 8'h00−8'h01 → 8'hFF, `cout`=0 (borrow), `overflow`=0.
3. Add 8'h7F+8'h01 → 8'h80, `cout`=0, `overflow`=1. Add 8'hFF+8'h01 → 8'h00, `cout`=1, `overflow`=0. Subtract 8'h80−8'h01 → 8'h7F, `overflow`=1.
4. Pulse `start` with new operands at cycles 3 and 8 of a busy operation → both ignored. The first result is unchanged, and a new `start` on the first IDLE cycle after DONE is accepted.
5. Assert `rst` on the 4th SHIFT cycle → next cycle all outputs are 0 and no `done` appears. A following add 8'h01+8'h02 yields 8'h03.
6. `rst` and `start` high in the same cycle → no operation starts and `busy` stays 0.
